// File: rtl/cache_control_if.sv
// Handshake bundle between the L1 cache control FSM, the CPU port, the cache datapath and L2/MM.
// master = the control FSM, slave = the surrounding CPU/datapath/memory side.
interface cache_control_if;
  logic cpu_read;
  logic cpu_write;
  logic cpu_resp;
  logic hit;
  logic dirty_out;
  logic ld_v;
  logic ld_tag;
  logic ld_data;
  logic ld_dirty;
  logic dirty_in;
  logic wr_mode;
  logic addr_sel;
  logic mem_read;
  logic mem_write;
  logic mem_resp;

  modport master (
    input  cpu_read, cpu_write, hit, dirty_out, mem_resp,
    output cpu_resp, ld_v, ld_tag, ld_data, ld_dirty, dirty_in, wr_mode, addr_sel,
           mem_read, mem_write
  );

  modport slave (
    output cpu_read, cpu_write, hit, dirty_out, mem_resp,
    input  cpu_resp, ld_v, ld_tag, ld_data, ld_dirty, dirty_in, wr_mode, addr_sel,
           mem_read, mem_write
  );
endinterface

// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set L1 cache: hit/miss decision, dirty writeback, line allocate.
// Optional performance counters (hit_cnt, miss_cnt, wb_cnt) are built when CACHE_PERF_CNT_EN is defined.
module cache_control #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  cache_control_if.master   bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_read || bus.cpu_write) begin
          state_d = COMPARE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (bus.hit) begin
          state_d = IDLE;
        end else if (bus.dirty_out) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (bus.mem_resp) begin
          state_d = ALLOCATE;
        end else begin
          state_d = WRITEBACK;
        end
      end
      ALLOCATE: begin
        if (bus.mem_resp) begin
          state_d = COMPARE;
        end else begin
          state_d = ALLOCATE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs per state plus the Mealy terms on hit and mem_resp.
  always_comb begin
    bus.cpu_resp  = 1'b0;
    bus.ld_v      = 1'b0;
    bus.ld_tag    = 1'b0;
    bus.ld_data   = 1'b0;
    bus.ld_dirty  = 1'b0;
    bus.dirty_in  = 1'b0;
    bus.wr_mode   = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cpu_resp = 1'b0;
      end
      COMPARE: begin
        if (bus.hit) begin
          bus.cpu_resp = 1'b1;
          // A simultaneous read+write request is served as a write.
          if (bus.cpu_write) begin
            bus.ld_data  = 1'b1;
            bus.wr_mode  = 1'b1;
            bus.ld_dirty = 1'b1;
            bus.dirty_in = 1'b1;
          end else begin
            bus.ld_data  = 1'b0;
          end
        end else begin
          bus.cpu_resp = 1'b0;
        end
      end
      WRITEBACK: begin
        bus.mem_write = 1'b1;
        bus.addr_sel  = 1'b1;
      end
      ALLOCATE: begin
        bus.mem_read = 1'b1;
        bus.addr_sel = 1'b0;
        if (bus.mem_resp) begin
          bus.ld_data  = 1'b1;
          bus.wr_mode  = 1'b0;
          bus.ld_tag   = 1'b1;
          bus.ld_v     = 1'b1;
          bus.ld_dirty = 1'b1;
          bus.dirty_in = 1'b0;
        end else begin
          bus.ld_data  = 1'b0;
        end
      end
      default: begin
        bus.cpu_resp = 1'b0;
      end
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic             recmp_q;
  logic             recmp_d;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q;
  logic [CNT_W-1:0] miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q;
  logic [CNT_W-1:0] wb_cnt_d;

  // Counter updates; recmp marks the compare that follows a line fill so it is not a hit.
  always_comb begin
    recmp_d    = recmp_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == ALLOCATE && bus.mem_resp) begin
      recmp_d = 1'b1;
    end else if (state_q == COMPARE) begin
      recmp_d = 1'b0;
    end else begin
      recmp_d = recmp_q;
    end
    if (state_q == COMPARE && bus.hit && !recmp_q) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (state_q == COMPARE && !bus.hit) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
    if (state_q == WRITEBACK && bus.mem_resp) begin
      wb_cnt_d = wb_cnt_q + CNT_W'(1);
    end else begin
      wb_cnt_d = wb_cnt_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recmp_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      recmp_q    <= recmp_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule
